// File: rtl/mc_ctrl_unit_pkg.sv
// Shared encodings for the multicycle MIPS control unit: ALU ops, FSM states,
// opcodes and R-type funct codes.
package mc_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_WB_I     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_e;

  // Which decode rule selects the ALU op; shared with the single-cycle path.
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_RTYPE = 2'd2,
    CLS_ITYPE = 2'd3
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

endpackage

// File: rtl/mc_ctrl_unit_if.sv
// Control/datapath boundary: instruction fields and ALU flags in, mux selects
// and enables out.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       zero;
  logic       overflow;
  logic [2:0] ALU_operation;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       exc;

  modport ctrl (
    input  opcode, funct, mem_ready, zero, overflow,
    output ALU_operation, alu_src_a, alu_src_b, pc_source, pc_write, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, exc
  );

  modport dp (
    output opcode, funct, mem_ready, zero, overflow,
    input  ALU_operation, alu_src_a, alu_src_b, pc_source, pc_write, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, exc
  );
endinterface

// File: rtl/mc_ctrl_unit_alu_op_dec.sv
// ALU operation decoder: maps a decode class plus opcode/funct to the 3-bit
// ALU_operation code.
module alu_op_dec
  import mc_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_op_o = ALU_ADD;
    case (cls_i)
      CLS_SUB: alu_op_o = ALU_SUB;
      CLS_RTYPE: begin
        case (funct_i)
          F_ADD, F_ADDU: alu_op_o = ALU_ADD;
          F_SUB, F_SUBU: alu_op_o = ALU_SUB;
          F_AND:         alu_op_o = ALU_AND;
          F_OR:          alu_op_o = ALU_OR;
          F_XOR:         alu_op_o = ALU_XOR;
          F_NOR:         alu_op_o = ALU_NOR;
          F_SLT:         alu_op_o = ALU_SLT;
          F_SRL:         alu_op_o = ALU_SRL;
          default:       alu_op_o = ALU_ADD;
        endcase
      end
      CLS_ITYPE: begin
        case (opcode_i)
          OP_SLTI: alu_op_o = ALU_SLT;
          OP_ANDI: alu_op_o = ALU_AND;
          OP_ORI:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and raises exc on illegal opcodes or trapping signed overflow.
module mc_ctrl_unit
  import mc_pkg::*;
#(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  mc_ctrl_if.ctrl         bus,
  output logic [ST_W-1:0] state_out
);

  state_e   state_q, state_d;
  logic     ovf_q, ovf_d;
  alu_cls_e alu_cls;
  logic [2:0] alu_op;

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_RTYPE:                          state_d = S_EXEC_R;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
          default:                           state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC_R: begin
        state_d = S_WB_R;
        // addu/subu never trap; only the signed forms latch overflow.
        ovf_d   = bus.overflow & ((bus.funct == F_ADD) | (bus.funct == F_SUB));
      end
      S_EXEC_I: begin
        state_d = S_WB_I;
        ovf_d   = bus.overflow & (bus.opcode == OP_ADDI);
      end
      S_WB_R, S_WB_I: begin
        state_d = S_FETCH;
        ovf_d   = 1'b0;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous and only touches control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    alu_cls        = CLS_ADD;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_source  = 2'b00;
    bus.pc_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.exc        = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // IR and PC load only in the cycle the fetch completes.
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        alu_cls       = CLS_RTYPE;
      end
      S_WB_R: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = ~ovf_q;
        bus.exc       = ovf_q;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        alu_cls       = CLS_SUB;
        bus.pc_source = 2'b01;
        bus.pc_write  = bus.zero;
      end
      S_JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        alu_cls       = CLS_ITYPE;
      end
      S_WB_I: begin
        bus.reg_write = ~ovf_q;
        bus.exc       = ovf_q;
      end
      S_ILLEGAL: bus.exc = 1'b1;
      default: ;
    endcase
  end

  alu_op_dec u_alu_op_dec (
    .cls_i    (alu_cls),
    .opcode_i (bus.opcode),
    .funct_i  (bus.funct),
    .alu_op_o (alu_op)
  );

  assign bus.ALU_operation = alu_op;
  assign state_out         = ST_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: expected per-cycle state/op/control vectors
// go through a scoreboard queue and are compared against the DUT.
module tb_mc_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_out;

  mc_ctrl_if bus ();

  mc_ctrl_unit #(.ST_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       exc;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctl_t;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [2:0] op;
    ctl_t       ctl;
  } exp_t;

  localparam ctl_t C_FWAIT   = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
  localparam ctl_t C_FGO     = '{pc_write:1'b1, mem_read:1'b1, ir_write:1'b1,
                                 alu_src_b:2'b01, default:'0};
  localparam ctl_t C_DEC     = '{alu_src_b:2'b11, default:'0};
  localparam ctl_t C_MADDR   = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctl_t C_MRD     = '{mem_read:1'b1, i_or_d:1'b1, default:'0};
  localparam ctl_t C_WBMEM   = '{reg_write:1'b1, mem_to_reg:1'b1, default:'0};
  localparam ctl_t C_MWR     = '{mem_write:1'b1, i_or_d:1'b1, default:'0};
  localparam ctl_t C_EXR     = '{alu_src_a:1'b1, default:'0};
  localparam ctl_t C_WBR_OK  = '{reg_write:1'b1, reg_dst:1'b1, default:'0};
  localparam ctl_t C_WBR_EXC = '{exc:1'b1, reg_dst:1'b1, default:'0};
  localparam ctl_t C_BR_T    = '{pc_write:1'b1, alu_src_a:1'b1, pc_source:2'b01, default:'0};
  localparam ctl_t C_BR_N    = '{alu_src_a:1'b1, pc_source:2'b01, default:'0};
  localparam ctl_t C_JMP     = '{pc_write:1'b1, pc_source:2'b10, default:'0};
  localparam ctl_t C_EXI     = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam ctl_t C_WBI_OK  = '{reg_write:1'b1, default:'0};
  localparam ctl_t C_WBI_EXC = '{exc:1'b1, default:'0};
  localparam ctl_t C_ILL     = '{exc:1'b1, default:'0};

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic ctl_t observe();
    ctl_t c;
    c.pc_write   = bus.pc_write;
    c.mem_read   = bus.mem_read;
    c.mem_write  = bus.mem_write;
    c.ir_write   = bus.ir_write;
    c.reg_write  = bus.reg_write;
    c.exc        = bus.exc;
    c.alu_src_a  = bus.alu_src_a;
    c.alu_src_b  = bus.alu_src_b;
    c.pc_source  = bus.pc_source;
    c.i_or_d     = bus.i_or_d;
    c.reg_dst    = bus.reg_dst;
    c.mem_to_reg = bus.mem_to_reg;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expected view of the current cycle, sample 1 ns after the falling
  // edge once inputs have settled, compare, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [2:0] op,
                     input ctl_t c);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.op  = op;
    e.ctl = c;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check({e.tag, "_state"}, 32'(state_out), 32'(e.st));
    check({e.tag, "_aluop"}, 32'(bus.ALU_operation), 32'(e.op));
    check({e.tag, "_ctl"}, 32'(observe()), 32'(e.ctl));
    @(negedge clk);
  endtask

  task automatic run_r(input string tag, input logic [5:0] f, input logic [2:0] op_exp,
                       input logic ovf, input logic trap);
    bus.opcode   = 6'h00;
    bus.funct    = f;
    bus.overflow = 1'b0;
    cyc({tag, "_f"}, 4'd0, 3'b010, C_FGO);
    cyc({tag, "_d"}, 4'd1, 3'b010, C_DEC);
    bus.overflow = ovf;
    cyc({tag, "_x"}, 4'd6, op_exp, C_EXR);
    bus.overflow = 1'b0;
    cyc({tag, "_w"}, 4'd7, 3'b010, trap ? C_WBR_EXC : C_WBR_OK);
  endtask

  task automatic run_i(input string tag, input logic [5:0] opc, input logic [2:0] op_exp,
                       input logic ovf, input logic trap);
    bus.opcode   = opc;
    bus.funct    = 6'h00;
    bus.overflow = 1'b0;
    cyc({tag, "_f"}, 4'd0, 3'b010, C_FGO);
    cyc({tag, "_d"}, 4'd1, 3'b010, C_DEC);
    bus.overflow = ovf;
    cyc({tag, "_x"}, 4'd10, op_exp, C_EXI);
    bus.overflow = 1'b0;
    cyc({tag, "_w"}, 4'd11, 3'b010, trap ? C_WBI_EXC : C_WBI_OK);
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.overflow  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state and fetch stall.
    check("rst_ovf", 32'(dut.ovf_q), 32'd0);
    cyc("fetch_wait0", 4'd0, 3'b010, C_FWAIT);
    cyc("fetch_wait1", 4'd0, 3'b010, C_FWAIT);
    bus.mem_ready = 1'b1;

    // R-type: signed traps, unsigned never trap, funct->op mapping.
    run_r("add",      6'h20, 3'b010, 1'b0, 1'b0);
    run_r("sub_ovf",  6'h22, 3'b110, 1'b1, 1'b1);
    run_r("subu_ovf", 6'h23, 3'b110, 1'b1, 1'b0);
    run_r("addu_ovf", 6'h21, 3'b010, 1'b1, 1'b0);
    run_r("and",      6'h24, 3'b000, 1'b0, 1'b0);
    run_r("or",       6'h25, 3'b001, 1'b0, 1'b0);
    run_r("xor",      6'h26, 3'b011, 1'b0, 1'b0);
    run_r("nor",      6'h27, 3'b100, 1'b1, 1'b0);
    run_r("slt",      6'h2A, 3'b111, 1'b0, 1'b0);
    run_r("srl",      6'h02, 3'b101, 1'b0, 1'b0);
    run_r("unk_fn",   6'h3E, 3'b010, 1'b0, 1'b0);

    // I-type arithmetic/logic.
    run_i("addi_ovf", 6'h08, 3'b010, 1'b1, 1'b1);
    run_i("ori_ovf",  6'h0D, 3'b001, 1'b1, 1'b0);
    run_i("slti",     6'h0A, 3'b111, 1'b0, 1'b0);
    run_i("andi",     6'h0C, 3'b000, 1'b0, 1'b0);
    run_i("addi",     6'h08, 3'b010, 1'b0, 1'b0);

    // lw with three wait cycles in MEM_RD.
    bus.opcode = 6'h23;
    cyc("lw_f", 4'd0, 3'b010, C_FGO);
    cyc("lw_d", 4'd1, 3'b010, C_DEC);
    cyc("lw_a", 4'd2, 3'b010, C_MADDR);
    bus.mem_ready = 1'b0;
    cyc("lw_rd_w0", 4'd3, 3'b010, C_MRD);
    cyc("lw_rd_w1", 4'd3, 3'b010, C_MRD);
    cyc("lw_rd_w2", 4'd3, 3'b010, C_MRD);
    bus.mem_ready = 1'b1;
    cyc("lw_rd_go", 4'd3, 3'b010, C_MRD);
    cyc("lw_wb", 4'd4, 3'b010, C_WBMEM);

    // sw, no wait.
    bus.opcode = 6'h2B;
    cyc("sw_f", 4'd0, 3'b010, C_FGO);
    cyc("sw_d", 4'd1, 3'b010, C_DEC);
    cyc("sw_a", 4'd2, 3'b010, C_MADDR);
    cyc("sw_wr", 4'd5, 3'b010, C_MWR);

    // beq taken, then not taken.
    bus.opcode = 6'h04;
    bus.zero   = 1'b1;
    cyc("beqT_f", 4'd0, 3'b010, C_FGO);
    cyc("beqT_d", 4'd1, 3'b010, C_DEC);
    cyc("beqT_b", 4'd8, 3'b110, C_BR_T);
    bus.zero = 1'b0;
    cyc("beqN_f", 4'd0, 3'b010, C_FGO);
    cyc("beqN_d", 4'd1, 3'b010, C_DEC);
    cyc("beqN_b", 4'd8, 3'b110, C_BR_N);

    // j.
    bus.opcode = 6'h02;
    cyc("j_f", 4'd0, 3'b010, C_FGO);
    cyc("j_d", 4'd1, 3'b010, C_DEC);
    cyc("j_j", 4'd9, 3'b010, C_JMP);

    // Illegal opcode.
    bus.opcode = 6'h3F;
    cyc("ill_f", 4'd0, 3'b010, C_FGO);
    cyc("ill_d", 4'd1, 3'b010, C_DEC);
    cyc("ill_x", 4'd12, 3'b010, C_ILL);

    // Reset while stalled in MEM_WR.
    bus.opcode = 6'h2B;
    cyc("swr_f", 4'd0, 3'b010, C_FGO);
    cyc("swr_d", 4'd1, 3'b010, C_DEC);
    cyc("swr_a", 4'd2, 3'b010, C_MADDR);
    bus.mem_ready = 1'b0;
    cyc("swr_wr", 4'd5, 3'b010, C_MWR);
    rst = 1'b1;
    cyc("swr_rst", 4'd5, 3'b010, C_MWR);
    rst = 1'b0;
    check("swr_rst_ovf", 32'(dut.ovf_q), 32'd0);
    cyc("swr_after", 4'd0, 3'b010, C_FWAIT);
    bus.mem_ready = 1'b1;

    // Reset in WB_R with a latched overflow must clear it.
    bus.opcode = 6'h00;
    bus.funct  = 6'h20;
    cyc("addr_f", 4'd0, 3'b010, C_FGO);
    cyc("addr_d", 4'd1, 3'b010, C_DEC);
    bus.overflow = 1'b1;
    cyc("addr_x", 4'd6, 3'b010, C_EXR);
    bus.overflow = 1'b0;
    check("addr_ovf_set", 32'(dut.ovf_q), 32'd1);
    rst = 1'b1;
    cyc("addr_w_rst", 4'd7, 3'b010, C_WBR_EXC);
    rst = 1'b0;
    check("addr_rst_ovf", 32'(dut.ovf_q), 32'd0);

    // Clean add afterwards: no stale trap.
    run_r("add_post", 6'h20, 3'b010, 1'b0, 1'b0);
    cyc("final_fetch", 4'd0, 3'b010, C_FGO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
